// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op classes and the ID/EX control bundle.
package mips_pkg;

    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned ALUOP_W   = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mips_ctrl_decode_if.sv
// ID-stage control bus: opcode/handshake from the pipeline, decoded controls back to it.
interface mips_ctrl_decode_if;
    import mips_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                valid;
    logic                stall;
    logic                flush;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic [ALUOP_W-1:0]  alu_op;
    logic                illegal_op;

    modport master (
        output opcode, valid, stall, flush,
        input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, jump, alu_op, illegal_op
    );

    modport slave (
        input  opcode, valid, stall, flush,
        output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, jump, alu_op, illegal_op
    );
endinterface

// File: rtl/mips_ctrl_comb.sv
// Pure combinational opcode -> control decode. CU_IMM_OPS_EN adds andi/ori/slti.
module mips_ctrl_comb
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_valid,
    output ctrl_t               o_ctrl,
    output logic                o_illegal
);

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        if (i_valid) begin
            case (i_opcode)
                OP_RTYPE: begin
                    o_ctrl.reg_dst   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.alu_op    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.mem_to_reg = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.mem_read   = 1'b1;
                    o_ctrl.alu_op     = ALUOP_ADD;
                end
                OP_SW: begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.mem_write = 1'b1;
                    o_ctrl.alu_op    = ALUOP_ADD;
                end
                OP_BEQ: begin
                    o_ctrl.branch = 1'b1;
                    o_ctrl.alu_op = ALUOP_SUB;
                end
                OP_ADDI: begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.alu_op    = ALUOP_ADD;
                end
                OP_J: begin
                    o_ctrl.jump = 1'b1;
                end
`ifdef CU_IMM_OPS_EN
                // ALU control picks and/or/slt from the opcode bits itself
                OP_ANDI, OP_ORI, OP_SLTI: begin
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.alu_op    = ALUOP_IMM;
                end
`endif
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_ctrl_decode.sv
// ID-stage main control decoder with ID/EX register (stall holds, flush/reset bubble).
// Optional macro CU_IMM_OPS_EN enables andi/ori/slti decode.
module mips_ctrl_decode
    import mips_pkg::*;
#(
    parameter int unsigned REG_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_ctrl_decode_if.slave    bus
);

    ctrl_t w_dec;
    logic  w_dec_illegal;
    ctrl_t w_out;
    logic  w_out_illegal;

    mips_ctrl_comb u_comb (
        .i_opcode  (bus.opcode),
        .i_valid   (bus.valid),
        .o_ctrl    (w_dec),
        .o_illegal (w_dec_illegal)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            ctrl_t r_ctrl;
            logic  r_illegal;

            // Priority: reset, then flush (beats stall), then stall hold, then load
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ctrl    <= CTRL_BUBBLE;
                    r_illegal <= 1'b0;
                end else if (bus.flush) begin
                    r_ctrl    <= CTRL_BUBBLE;
                    r_illegal <= 1'b0;
                end else if (!bus.stall) begin
                    r_ctrl    <= w_dec;
                    r_illegal <= w_dec_illegal;
                end
            end

            assign w_out         = r_ctrl;
            assign w_out_illegal = r_illegal;
        end else begin : g_comb
            assign w_out         = bus.flush ? CTRL_BUBBLE : w_dec;
            assign w_out_illegal = bus.flush ? 1'b0 : w_dec_illegal;
        end
    endgenerate

    assign bus.reg_dst    = w_out.reg_dst;
    assign bus.alu_src    = w_out.alu_src;
    assign bus.mem_to_reg = w_out.mem_to_reg;
    assign bus.reg_write  = w_out.reg_write;
    assign bus.mem_read   = w_out.mem_read;
    assign bus.mem_write  = w_out.mem_write;
    assign bus.branch     = w_out.branch;
    assign bus.jump       = w_out.jump;
    assign bus.alu_op     = w_out.alu_op;
    assign bus.illegal_op = w_out_illegal;

endmodule

// File: tb/tb_mips_ctrl_decode.sv
// Directed bench for mips_ctrl_decode (REG_OUT=1) with hand-computed control vectors.
module tb_mips_ctrl_decode;

    // Vector layout: {illegal, reg_dst, alu_src, mem_to_reg, reg_write,
    //                 mem_read, mem_write, branch, jump, alu_op[1:0]}
    localparam logic [10:0] E_BUB = 11'b0_0_0_0_0_0_0_0_0_00;
    localparam logic [10:0] E_RTY = 11'b0_1_0_0_1_0_0_0_0_10;
    localparam logic [10:0] E_LW  = 11'b0_0_1_1_1_1_0_0_0_00;
    localparam logic [10:0] E_SW  = 11'b0_0_1_0_0_0_1_0_0_00;
    localparam logic [10:0] E_BEQ = 11'b0_0_0_0_0_0_0_1_0_01;
    localparam logic [10:0] E_ADI = 11'b0_0_1_0_1_0_0_0_0_00;
    localparam logic [10:0] E_J   = 11'b0_0_0_0_0_0_0_0_1_00;
    localparam logic [10:0] E_ILL = 11'b1_0_0_0_0_0_0_0_0_00;
`ifdef CU_IMM_OPS_EN
    localparam logic [10:0] E_IMM = 11'b0_0_1_0_1_0_0_0_0_11;
`else
    localparam logic [10:0] E_IMM = E_ILL;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_ctrl_decode_if bus ();

    mips_ctrl_decode #(.REG_OUT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {bus.illegal_op, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.alu_op};
    endfunction

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, check vector and invariants
    task automatic step_chk(input string tag, input logic [10:0] exp);
        logic [10:0] v;
        @(posedge clk);
        #1;
        v = observed();
        chk(tag, v, exp);
        chk({tag, "_inv"}, {8'b0, v[5] & v[4], v[3] & v[2], v[6] & v[4]}, 11'b0);
    endtask

    task automatic drive(input logic [5:0] op, input logic vld, input logic stl, input logic fl);
        bus.opcode = op;
        bus.valid  = vld;
        bus.stall  = stl;
        bus.flush  = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(6'h23, 1'b1, 1'b0, 1'b0);
        step_chk("rst0", E_BUB);
        step_chk("rst1", E_BUB);
        rst = 1'b0;
        step_chk("lw_after_rst", E_LW);

        drive(6'h00, 1'b1, 1'b0, 1'b0);
        chk("latency_hold", observed(), E_LW);
        step_chk("rtype", E_RTY);
        drive(6'h2B, 1'b1, 1'b0, 1'b0);
        step_chk("sw", E_SW);
        drive(6'h04, 1'b1, 1'b0, 1'b0);
        step_chk("beq", E_BEQ);
        drive(6'h08, 1'b1, 1'b0, 1'b0);
        step_chk("addi", E_ADI);
        drive(6'h02, 1'b1, 1'b0, 1'b0);
        step_chk("j", E_J);

        drive(6'h00, 1'b1, 1'b0, 1'b0);
        step_chk("stall_load", E_RTY);
        drive(6'h2B, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_chk($sformatf("stall%0d", i), E_RTY);
        drive(6'h2B, 1'b1, 1'b0, 1'b0);
        step_chk("stall_release", E_SW);

        drive(6'h23, 1'b1, 1'b0, 1'b0);
        step_chk("flush_load", E_LW);
        drive(6'h23, 1'b1, 1'b1, 1'b1);
        step_chk("flush_over_stall", E_BUB);
        drive(6'h23, 1'b1, 1'b1, 1'b0);
        step_chk("stall_holds_bubble", E_BUB);

        drive(6'h3F, 1'b1, 1'b0, 1'b0);
        step_chk("illegal", E_ILL);
        drive(6'h3F, 1'b0, 1'b0, 1'b0);
        step_chk("illegal_invalid", E_BUB);
        drive(6'h23, 1'b0, 1'b0, 1'b0);
        step_chk("lw_invalid", E_BUB);

        drive(6'h0D, 1'b1, 1'b0, 1'b0);
        step_chk("ori", E_IMM);
        drive(6'h0C, 1'b1, 1'b0, 1'b0);
        step_chk("andi", E_IMM);
        drive(6'h0A, 1'b1, 1'b0, 1'b0);
        step_chk("slti", E_IMM);
        drive(6'h01, 1'b1, 1'b0, 1'b0);
        step_chk("illegal_01", E_ILL);

        drive(6'h23, 1'b1, 1'b0, 1'b0);
        step_chk("mid_load", E_LW);
        rst = 1'b1;
        drive(6'h00, 1'b1, 1'b1, 1'b0);
        step_chk("mid_rst_stall", E_BUB);
        rst = 1'b0;
        drive(6'h00, 1'b1, 1'b0, 1'b0);
        step_chk("post_rst", E_RTY);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_decode.md
Name: mips_ctrl_decode

Overview:
- Main control decoder for the MIPS pipeline's ID stage.
- Decodes the 6-bit primary opcode into datapath control signals: register-destination select, ALU source, ALU op class, memory read/write, writeback select, branch, jump.
- Registers the signals into the ID/EX boundary, with stall (hold) and flush (bubble) support.
- Feeds the ALU control decoder (alu_op), the operand/writeback muxes, data memory, and PC-select logic.

Parameters:
- OPCODE_W, 6, opcode width; fixed, not overridable in practice.
- REG_OUT, 1: 1 = control outputs registered (1-cycle latency); 0 = outputs combinational from opcode/valid/flush, with clk/rst/stall unused.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction[31:26]
- valid  in  1  opcode belongs to a real instruction; 0 decodes as bubble
- stall  in  1  hold registered outputs
- flush  in  1  force bubble into the output register
- reg_dst  out  1  1 = write rd, 0 = write rt
- alu_src  out  1  1 = sign-extended immediate, 0 = rt data
- mem_to_reg  out  1  1 = writeback from memory read data
- reg_write  out  1  register file write enable
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- branch  out  1  conditional branch (beq), ANDed with ALU zero downstream
- jump  out  1  unconditional jump
- alu_op  out  2  00 add, 01 subtract (compare), 10 use funct field, 11 immediate-logic (see optional feature)
- illegal_op  out  1  valid opcode not in decode table

Behaviour:
Decode table (signals not listed are 0):
- 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10
- 0x23 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00
- 0x2B sw: alu_src=1, mem_write=1, alu_op=00
- 0x04 beq: branch=1, alu_op=01
- 0x08 addi: alu_src=1, reg_write=1, alu_op=00
- 0x02 j: jump=1

Bubble, illegal opcodes and reset:
- Bubble = all control outputs 0, alu_op=00, illegal_op=0.
- valid=0 decodes as a bubble.
- Any other opcode with valid=1: all controls 0 and illegal_op=1. Side-effect-free, so no register or memory write.
- Reset: all outputs 0 the cycle after rst is sampled high, regardless of stall/flush/valid.

Registered update (REG_OUT=1), at each posedge, priority order:
1. rst → bubble.
2. flush → bubble; flush overrides stall.
3. stall → hold previous values.
4. Otherwise load decode(opcode, valid).

Timing and invariants:
- Latency exactly 1 cycle. Reset applied mid-stream discards the pending decode.
- Never assert mem_read and mem_write together.
- Never assert branch and jump together.
- reg_write=1 implies mem_write=0.

Optional Feature:
CU_IMM_OPS_EN
- Defined: additionally decode the following, all with alu_src=1, reg_write=1, alu_op=11:
  - 0x0C andi
  - 0x0D ori
  - 0x0A slti
- The ALU control decoder then selects the operation from the opcode bits.
- Undefined: these three opcodes are illegal (illegal_op=1, controls 0), and alu_op=11 is never produced.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ANDI, OP_ORI, OP_SLTI
  - alu_op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_IMM
  - a packed struct ctrl_t bundling the nine control fields, with a CTRL_BUBBLE constant
- One natural sub-module: mips_ctrl_comb, a pure combinational opcode→ctrl_t decoder. The top wraps it with the stall/flush/reset register.

Test Plan:
- rst=1 for 2 cycles with opcode=0x23, valid=1 → all outputs 0. Release rst → next cycle mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00.
- Sequence 0x00, 0x2B, 0x04, 0x08, 0x02 on consecutive cycles → each decode appears 1 cycle later:
  - 0x00: reg_dst=1, reg_write=1, alu_op=10
  - 0x2B: mem_write=1, alu_src=1
  - 0x04: branch=1, alu_op=01
  - 0x08: alu_src=1, reg_write=1
  - 0x02: jump=1
- Load 0x00, then stall=1 for 3 cycles while opcode=0x2B → outputs stay R-type. Deassert stall → sw decode one cycle later.
- stall=1 and flush=1 together with held lw outputs → outputs become bubble next cycle.
- opcode=0x3F, valid=1 → illegal_op=1, all controls 0. Same opcode with valid=0 → illegal_op=0.
- opcode=0x0D:
  - with CU_IMM_OPS_EN: alu_src=1, reg_write=1, alu_op=11, illegal_op=0
  - without it: illegal_op=1, controls 0
